ca_stream_controller: RTL and testbench

- Controller that sits directly upstream of the 64-cell rule-110 array and drives its pin-level interface: write_n, halt_n, block address, data in, data out.
- Loads an initial row from a byte stream (valid/ready) into the array, block by block.
- Releases the array for exactly a programmed number of generations, then re-halts it.
- Streams the resulting row back out as bytes (valid/ready).

---
 rtl/ca_stream_controller.sv | 166 ++++++++++++++++
 tb/tb_ca_stream_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_stream_controller.sv
// Loads a 7-block row into the rule-110 array, runs it for gen_count generations, streams the row back.
// Load writes land one cycle after each s_valid/s_ready handshake; readback holds m_data/ca_addr until m_ready.
module ca_stream_controller #(
  parameter int NUM_BLOCKS = 7,
  parameter int ADDR_W     = 6,
  parameter int GEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GEN_W-1:0]  gen_count,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        ca_data_in,
  output logic              ca_write_n,
  output logic              ca_halt_n,
  output logic [ADDR_W-1:0] ca_addr,
  input  logic [7:0]        ca_data_out
);

  localparam int BLK_W = 3;
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RD_SET,
    S_RD_OUT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [BLK_W-1:0] r_blk, w_blk_nxt;
  logic [GEN_W-1:0] r_gen, w_gen_nxt;
  logic             r_write_n, w_write_n_nxt;
  logic             r_halt_n, w_halt_n_nxt;
  logic [BLK_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]       r_din, w_din_nxt;
  logic [7:0]       r_m_data, w_m_data_nxt;
  logic             r_m_valid, w_m_valid_nxt;
  logic             r_done, w_done_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_blk_nxt     = r_blk;
    w_gen_nxt     = r_gen;
    w_write_n_nxt = 1'b1;
    w_halt_n_nxt  = 1'b0;
    w_addr_nxt    = r_addr;
    w_din_nxt     = r_din;
    w_m_data_nxt  = r_m_data;
    w_m_valid_nxt = r_m_valid;
    w_done_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_gen_nxt   = gen_count;
          w_blk_nxt   = '0;
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        if (s_valid) begin
          w_write_n_nxt = 1'b0;
          w_addr_nxt    = r_blk;
          w_din_nxt     = s_data;
          if (r_blk == LAST_BLK) begin
            w_blk_nxt   = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_blk_nxt = r_blk + BLK_W'(1);
          end
        end
      end

      // First RUN cycle is the final write cycle, so halt_n can only rise after it.
      S_RUN: begin
        if (!r_halt_n) begin
          if (r_gen == '0) begin
            w_addr_nxt  = '0;
            w_state_nxt = S_RD_SET;
          end else begin
            w_halt_n_nxt = 1'b1;
          end
        end else begin
          w_gen_nxt = r_gen - GEN_W'(1);
          if (r_gen == GEN_W'(1)) begin
            w_addr_nxt  = '0;
            w_state_nxt = S_RD_SET;
          end else begin
            w_halt_n_nxt = 1'b1;
          end
        end
      end

      S_RD_SET: begin
        w_m_data_nxt  = ca_data_out;
        w_m_valid_nxt = 1'b1;
        w_state_nxt   = S_RD_OUT;
      end

      S_RD_OUT: begin
        if (m_ready) begin
          w_m_valid_nxt = 1'b0;
          if (r_blk == LAST_BLK) begin
            w_blk_nxt   = '0;
            w_addr_nxt  = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_blk_nxt   = r_blk + BLK_W'(1);
            w_addr_nxt  = r_blk + BLK_W'(1);
            w_state_nxt = S_RD_SET;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_blk     <= '0;
      r_gen     <= '0;
      r_write_n <= 1'b1;
      r_halt_n  <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_blk     <= w_blk_nxt;
      r_gen     <= w_gen_nxt;
      r_write_n <= w_write_n_nxt;
      r_halt_n  <= w_halt_n_nxt;
      r_addr    <= w_addr_nxt;
      r_din     <= w_din_nxt;
      r_m_data  <= w_m_data_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign s_ready    = (r_state == S_LOAD);
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign ca_data_in = r_din;
  assign ca_write_n = r_write_n;
  assign ca_halt_n  = r_halt_n;
  assign ca_addr    = {{(ADDR_W - BLK_W){1'b0}}, r_addr};

endmodule

// File: tb/tb_ca_stream_controller.sv
// Bench for ca_stream_controller with a behavioural 64-cell rule-110 array attached to its pins.
module tb_ca_stream_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] gen_count = '0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        busy, done;
  logic [7:0]  ca_data_in;
  logic        ca_write_n, ca_halt_n;
  logic [5:0]  ca_addr;
  logic [7:0]  ca_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ca_stream_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gen_count(gen_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done),
    .ca_data_in(ca_data_in), .ca_write_n(ca_write_n), .ca_halt_n(ca_halt_n),
    .ca_addr(ca_addr), .ca_data_out(ca_data_out)
  );

  function automatic logic [63:0] gen_step(input logic [63:0] c);
    logic [7:0]  rule;
    logic [63:0] n;
    int          nb;
    rule = 8'd110;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      nb = 4 * int'(c[(i + 1) % 64]) + 2 * int'(c[i]) + int'(c[(i + 63) % 64]);
      n[i] = rule[nb];
    end
    return n;
  endfunction

  function automatic logic [63:0] evolve(input logic [63:0] c, input int gens);
    logic [63:0] s;
    s = c;
    for (int g = 0; g < gens; g++) s = gen_step(s);
    return s;
  endfunction

  // Array fixture: block 7 aliases to block 0, one generation per halt_n-high clock.
  logic [63:0] arr = '0;
  logic [2:0]  w_idx;
  assign w_idx = (ca_addr[2:0] == 3'd7) ? 3'd0 : ca_addr[2:0];
  assign ca_data_out = arr[w_idx*8 +: 8];

  always @(posedge clk) begin
    if (!ca_write_n) arr[w_idx*8 +: 8] <= ca_data_in;
    else if (ca_halt_n) arr <= gen_step(arr);
  end

  int         cyc = 0, wr_cnt = 0, halt_cnt = 0, halt_rises = 0, viol = 0;
  int         last_wr_cyc = -1, last_rise_cyc = -1;
  logic       prev_halt = 1'b0;
  logic [2:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!ca_write_n) begin
      wr_cnt++;
      wr_addr_q.push_back(ca_addr[2:0]);
      wr_data_q.push_back(ca_data_in);
      last_wr_cyc = cyc;
    end
    if (ca_halt_n) begin
      halt_cnt++;
      if (!prev_halt) begin
        halt_rises++;
        last_rise_cyc = cyc;
      end
    end
    if ((ca_halt_n && !ca_write_n) || ca_addr[5:3] != 3'd0) viol++;
    prev_halt = ca_halt_n;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic do_run(input logic [15:0] g, input logic [55:0] row, input bit gap,
                        input int stall_blk, input int stall_len, input bit glitch,
                        input bit rnd_rdy, input int exp_halt);
    int          wr0, h0, r0, v0, budget, bad;
    logic [63:0] exp_arr;
    logic [7:0]  held;
    wr0 = wr_cnt; h0 = halt_cnt; r0 = halt_rises; v0 = viol;
    exp_arr = evolve({arr[63:56], row}, int'(g));

    @(posedge clk); #1;
    gen_count = g; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("s_ready_in_load", s_ready, 1);

    for (int k = 0; k < 7; k++) begin
      if (gap && k > 0) begin
        s_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
      end
      s_valid = 1'b1;
      s_data  = row[k*8 +: 8];
      if (glitch && k == 3) begin start = 1'b1; gen_count = ~g; end
      @(posedge clk); #1;
      start = 1'b0; gen_count = g;
    end
    s_valid = 1'b0;
    chk("s_ready_after_load", s_ready, 0);

    for (int k = 0; k < 7; k++) begin
      budget = 0;
      while (!m_valid && budget < 70000) begin
        @(posedge clk); #1;
        budget++;
      end
      if (!m_valid) begin
        fail_now("readback_wait");
        break;
      end
      chk("rd_data", m_data, exp_arr[k*8 +: 8]);
      chk("rd_addr", ca_addr, k);
      if (k == stall_blk) begin
        held = m_data;
        bad = 0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          if (!m_valid || m_data !== held || ca_addr !== 6'(k)) bad++;
        end
        chk("stall_stable", bad, 0);
      end else if (rnd_rdy) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      m_ready = 1'b1;
      if (glitch && k == 2) begin start = 1'b1; gen_count = ~g; end
      @(posedge clk); #1;
      m_ready = 1'b0; start = 1'b0; gen_count = g;
      if (k < 6) begin
        chk("m_valid_drop", m_valid, 0);
        chk("next_addr", ca_addr, k + 1);
      end
    end
    chk("done_pulse", done, 1);
    chk("busy_idle", busy, 0);
    chk("addr_home", ca_addr, 0);
    @(posedge clk); #1;
    chk("done_single", done, 0);

    chk("write_count", wr_cnt - wr0, 7);
    if (wr_cnt - wr0 == 7) begin
      bad = 0;
      for (int k = 0; k < 7; k++)
        if (wr_addr_q[wr0 + k] !== 3'(k) || wr_data_q[wr0 + k] !== row[k*8 +: 8]) bad++;
      chk("write_seq", bad, 0);
    end
    chk("halt_cycles", halt_cnt - h0, exp_halt);
    chk("halt_one_burst", halt_rises - r0, (exp_halt != 0) ? 1 : 0);
    chk("halt_write_overlap", viol - v0, 0);
    if (exp_halt != 0) chk("halt_after_write", last_rise_cyc > last_wr_cyc, 1);
  endtask

  typedef struct {
    logic [15:0] gen;
    logic [55:0] row;
    bit          gap;
    int          stall_blk;
    int          stall_len;
    bit          glitch;
    int          exp_halt;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] rnd64;
  int          hc, budget;

  initial begin
    vecs[0] = '{16'd0, 56'h07_06_05_04_03_02_01, 1'b0, -1, 0,  1'b0, 0};
    vecs[1] = '{16'd5, 56'h0,                    1'b0, -1, 0,  1'b0, 5};
    vecs[2] = '{16'd3, 56'h5A_C3_0F_81_7E_24_99, 1'b1, -1, 0,  1'b0, 3};
    vecs[3] = '{16'd2, 56'h01_00_80_00_10_00_FF, 1'b0, 3,  10, 1'b0, 2};
    vecs[4] = '{16'd7, 56'hDE_AD_BE_EF_12_34_56, 1'b0, -1, 0,  1'b1, 7};
    vecs[5] = '{16'd1, 56'hFF_FF_FF_FF_FF_FF_FF, 1'b1, 6,  3,  1'b0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_write_n", ca_write_n, 1);
    chk("rst_halt_n", ca_halt_n, 0);
    chk("rst_addr", ca_addr, 0);
    chk("rst_data_in", ca_data_in, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      do_run(vecs[i].gen, vecs[i].row, vecs[i].gap, vecs[i].stall_blk,
             vecs[i].stall_len, vecs[i].glitch, 1'b0, vecs[i].exp_halt);

    for (int i = 0; i < 12; i++) begin
      rnd64 = {$urandom(), $urandom()};
      hc = int'($urandom_range(0, 12));
      do_run(16'(hc), rnd64[55:0], 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b1, hc);
    end

    // Asynchronous reset in the third halt_n-high cycle of a 10-generation run.
    @(posedge clk); #1;
    gen_count = 16'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      s_valid = 1'b1; s_data = 8'($urandom());
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    hc = 0; budget = 0;
    while (hc < 3 && budget < 50) begin
      @(posedge clk); #1;
      if (ca_halt_n) hc++;
      budget++;
    end
    if (hc < 3) fail_now("reach_third_halt");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_halt_n", ca_halt_n, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_write_n", ca_write_n, 1);
    chk("mid_rst_s_ready", s_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rnd64 = {$urandom(), $urandom()};
    do_run(16'd4, rnd64[55:0], 1'b0, -1, 0, 1'b0, 1'b1, 4);

    rnd64 = {$urandom(), $urandom()};
    do_run(16'hFFFF, rnd64[55:0], 1'b0, -1, 0, 1'b1, 1'b0, 65535);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
